// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller driving the four pipeline latch enable/flush pairs and the PC write enable.
// Latency: all controls combinational from state and inputs; halt state and counters update on the next edge.
// Backpressure: a data wait freezes every latch, a load-use or fetch miss stalls the front end, and halt freezes everything until reset.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             mem_pcsrc,
  input  logic             wb_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             pc_en,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             exmem_flush,
  output logic             memwb_enable,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic active;     // per-cycle hazard rules are in effect
  logic dstall;     // data access outstanding in MEM
  logic load_use;   // ID needs a value the load in EX has not produced yet
  logic stall_ev;   // this cycle freezes a latch or inserts a bubble
  logic flush_ev;   // this cycle squashes wrong-path instructions

  // Hazard detection; register 0 is never a real dependency
  always_comb begin
    dstall   = mem_dreq & ~dhit;
    load_use = ex_dREN & (ex_wsel != '0) & ((ex_wsel == id_rs) | (ex_wsel == id_rt));
    active   = ~RST & (state_q != ST_HALT) & ~wb_halt;
    stall_ev = active & (dstall | (~mem_pcsrc & (load_use | ~ihit)));
    flush_ev = active & ~dstall & mem_pcsrc;
  end

  // State register and saturating performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state: halt is sticky, an outstanding data access parks in DWAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (wb_halt) begin
          state_d = ST_HALT;
        end else if (dstall) begin
          state_d = ST_DWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // Counter next values, held at all-ones once saturated
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_ev && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // Latch controls: first matching rule wins; reset, halt and wb_halt freeze all
  always_comb begin
    pc_en        = 1'b0;
    ifid_enable  = 1'b0;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b0;
    idex_flush   = 1'b0;
    exmem_enable = 1'b0;
    exmem_flush  = 1'b0;
    memwb_enable = 1'b0;
    memwb_flush  = 1'b0;
    if (active) begin
      if (dstall) begin
        // Whole pipe waits on the data access
        pc_en = 1'b0;
      end else if (mem_pcsrc) begin
        // Redirect: squash the three younger stages, retire the MEM instruction
        pc_en        = 1'b1;
        ifid_enable  = 1'b1;
        ifid_flush   = 1'b1;
        idex_enable  = 1'b1;
        idex_flush   = 1'b1;
        exmem_enable = 1'b1;
        exmem_flush  = 1'b1;
        memwb_enable = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, push a bubble into EX
        idex_enable  = 1'b1;
        idex_flush   = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
      end else if (~ihit) begin
        // Fetch not back yet: feed a bubble into ID, let the rest drain
        ifid_enable  = 1'b1;
        ifid_flush   = 1'b1;
        idex_enable  = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
      end else begin
        pc_en        = 1'b1;
        ifid_enable  = 1'b1;
        idex_enable  = 1'b1;
        exmem_enable = 1'b1;
        memwb_enable = 1'b1;
      end
    end
  end

  // Status outputs
  always_comb begin
    halted    = (state_q == ST_HALT);
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control-side counterpart of the pipeline latches: generates the enable/flush pair consumed by every stage latch (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC write enable.
- Resolves memory wait states, load-use hazards, taken branches/jumps resolved in MEM, and halt.
- Keeps a sticky halt state and saturating performance counters for stall and flush cycles.

Parameters:
CNT_W, 32, width of stall/flush performance counters
REG_W, 5, register-select width (matches regbits_t)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
mem_dreq  in  1  dREN or dWEN of instruction in MEM
mem_pcsrc  in  1  branch taken / jump resolved in MEM (PC redirect)
wb_halt  in  1  halt instruction in WB
ex_dREN  in  1  instruction in EX is a load
ex_wsel  in  REG_W  destination of instruction in EX
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
pc_en  out  1  PC register write enable
ifid_enable, ifid_flush  out  1 each  IF/ID latch controls
idex_enable, idex_flush  out  1 each  ID/EX latch controls
exmem_enable, exmem_flush  out  1 each  EX/MEM latch controls
memwb_enable, memwb_flush  out  1 each  MEM/WB latch controls
halted  out  1  processor halted (sticky)
stall_cnt  out  CNT_W  cycles with any latch frozen or bubble inserted
flush_cnt  out  CNT_W  number of redirect flush events

Behaviour:
- Latch semantics: enable=0 holds the latch; enable=1 & flush=1 loads the bubble; enable=1 & flush=0 loads the input.
- FSM states: RUN, DWAIT, HALT. RST (sync) -> RUN, counters 0, halted 0.
- Outputs are combinational from state and inputs. Equivalent values while RST=1: all enables 0, all flushes 0, pc_en 0.
- HALT: entered on the edge after wb_halt=1 in RUN/DWAIT. Leave only by RST. All enables 0, pc_en 0, halted 1, counters frozen.
- Decision is per cycle in RUN/DWAIT, first match wins:
  1. dstall = mem_dreq & ~dhit: all enables 0, pc_en 0, no flush. Next state DWAIT. stall_cnt+1.
  2. mem_pcsrc (dstall false): pc_en 1; ifid, idex and exmem get enable 1, flush 1; memwb enable 1, flush 0. flush_cnt+1. Redirect wins over load-use and ~ihit.
  3. load-use = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt): pc_en 0, ifid_enable 0, idex enable 1 with flush 1, exmem/memwb advance. stall_cnt+1.
  4. ~ihit: pc_en 0, ifid enable 1 with flush 1 (fetch bubble), later stages advance. stall_cnt+1.
  5. Otherwise: all enables 1, flushes 0, pc_en 1.
- DWAIT exits to RUN on the cycle dhit=1. In that cycle the rules above apply normally, so a pending mem_pcsrc is honoured on the dhit cycle.
- wb_halt has priority over everything. In the cycle wb_halt=1, all enables are 0 and the FSM moves to HALT.
- Counters saturate at all-ones and never wrap. Simultaneous stall and flush in one cycle is impossible by priority.
- Register 0 as destination never triggers load-use.

Test Plan:
- Basic flow: RST 1 cycle, then ihit=1 and all else 0 -> all enables 1, flushes 0, pc_en 1, counters 0.
- Load-use: ex_dREN=1, ex_wsel=5, id_rt=5, ihit=1 -> pc_en 0, ifid_enable 0, idex_flush 1, stall_cnt increments by 1. Repeat with ex_wsel=0 -> no stall.
- Data wait: mem_dreq=1, dhit=0 for 3 cycles, then dhit=1 with mem_pcsrc=1 -> 3 frozen cycles (state DWAIT), stall_cnt=3. On the dhit cycle ifid/idex/exmem flush and flush_cnt=1.
- Redirect vs hazard: mem_pcsrc=1 together with load-use and ihit=0 -> redirect response only; stall_cnt unchanged.
- Halt: wb_halt=1 -> next cycle halted=1 and all enables 0 regardless of inputs for 10 cycles. RST=1 -> RUN, halted 0.
- Saturation with CNT_W=4: hold ihit=0 for 20 cycles -> stall_cnt stays at 15.
